// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the skid-buffer slice.
//   pipe_state_e : occupancy state of the two-entry skid buffer
//                  (EMPTY = 0 words, BUSY = 1 word in main, FULL = 2 words).
// ----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_skid_buffer_if.sv
// ----------------------------------------------------------------------------
// pipe_skid_buffer_if
// Bundles the upstream and downstream valid/ready/data handshakes of the
// skid buffer.
//   master : traffic source/sink side (drives in_valid, in_data, out_ready)
//   slave  : buffer side (drives in_ready, out_valid, out_data)
// ----------------------------------------------------------------------------
interface pipe_skid_buffer_if #(
    parameter int unsigned WORD_WIDTH = 8
);

    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface : pipe_skid_buffer_if

// File: rtl/pipe_data_reg.sv
// ----------------------------------------------------------------------------
// pipe_data_reg
// Clock-enabled payload register with asynchronous active-high reset.
//   clk_i : rising-edge clock
//   rst_i : asynchronous reset, loads RESET_VALUE
//   en_i  : load d_i at the next rising edge
//   d_i   : next payload
//   q_o   : registered payload
// ----------------------------------------------------------------------------
module pipe_data_reg #(
    parameter int unsigned           WORD_WIDTH  = 8,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [WORD_WIDTH-1:0] d_i,
    output logic [WORD_WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= RESET_VALUE;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule : pipe_data_reg

// File: rtl/pipe_skid_buffer.sv
// ----------------------------------------------------------------------------
// pipe_skid_buffer
// Two-entry valid/ready pipeline stage with fully registered outputs.
// The main register drives out_data_o; the skid register catches the one
// extra word accepted while the downstream stalls.
//   clk_i       : rising-edge clock
//   rst_i       : asynchronous active-high reset (empties the buffer)
//   clear_i     : synchronous flush of held words, wins over any transfer
//   in_valid_i  : upstream word valid
//   in_ready_o  : buffer can accept a word
//   in_data_i   : upstream payload
//   out_valid_o : downstream word valid
//   out_ready_i : downstream accepts word
//   out_data_o  : downstream payload
// ----------------------------------------------------------------------------
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int unsigned           WORD_WIDTH  = 8,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WORD_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WORD_WIDTH-1:0] out_data_o
);

    pipe_state_e           state;
    pipe_state_e           state_next;
    logic                  out_valid_q;
    logic                  in_ready_q;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  main_en;
    logic                  skid_en;
    logic                  main_from_skid;
    logic [WORD_WIDTH-1:0] main_d;
    logic [WORD_WIDTH-1:0] skid_q;

    // Handshake flags are derived from the registered output copies so the
    // transfer decisions match exactly what the neighbours observe.
    assign in_xfer  = in_valid_i  & in_ready_q;
    assign out_xfer = out_ready_i & out_valid_q;

    // valid/ready are kept as dedicated flops loaded from the next state,
    // so no input reaches an output without passing a register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state       <= state_next;
            out_valid_q <= (state_next != EMPTY);
            in_ready_q  <= (state_next != FULL);
        end
    end

    always_comb begin
        state_next     = state;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;

        if (clear_i) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state_next = BUSY;
                        main_en    = 1'b1;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_en = 1'b1;
                    end else if (in_xfer) begin
                        state_next = FULL;
                        skid_en    = 1'b1;
                    end else if (out_xfer) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_next     = BUSY;
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data_i;

    pipe_data_reg #(
        .WORD_WIDTH (WORD_WIDTH),
        .RESET_VALUE(RESET_VALUE)
    ) u_main_reg (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .en_i (main_en),
        .d_i  (main_d),
        .q_o  (out_data_o)
    );

    pipe_data_reg #(
        .WORD_WIDTH (WORD_WIDTH),
        .RESET_VALUE(RESET_VALUE)
    ) u_skid_reg (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .en_i (skid_en),
        .d_i  (in_data_i),
        .q_o  (skid_q)
    );

    assign out_valid_o = out_valid_q;
    assign in_ready_o  = in_ready_q;

endmodule : pipe_skid_buffer
